oit_rr_arbiter: RTL and testbench
=================================

# oit_rr_arbiter

Round-robin arbiter that shares one `oitMux`-style datapath between COUNT requesters. It grants one requester at a time and drives the mux select. It forwards the granted requester's data word to a single downstream consumer under a valid/ready handshake. A hold limit bounds how many transfers one requester may make before it must give up the grant, which guarantees fairness.

## Interface
- COUNT, 4, number of requesters (2..16)
- WIDTH, 8, bits per data word
- MAX_HOLD, 4, max transfers per grant; 0 = unlimited
- SEL_W (derived), oitBits(COUNT) = ceil(log2 COUNT), minimum 1
- clock  in  1  single clock; everything updates on posedge
- reset  in  1  synchronous, active-high
- req  in  COUNT  req[i] high = requester i has a word available
- in  in  COUNT*WIDTH  word of requester i is in[i*WIDTH +: WIDTH]
- ready  in  1  downstream accepts out this cycle
- grant  out  COUNT  one-hot registered grant; all zero when idle
- select  out  SEL_W  registered index of current/last grantee
- valid  out  1  combinational: grant active and req[select] high
- out  out  WIDTH  combinational: in[select*WIDTH +: WIDTH]
- xfer  out  1  combinational: valid & ready (transfer this cycle)

## Operation
- State machine with two states, IDLE and BUSY. Internal registers: ptr (SEL_W bits, next priority index) and hold (count of transfers in the current grant).
- **IDLE**
  - grant = 0.
  - If req != 0: choose g = first index i with req[i] = 1, scanning ptr, ptr+1, … modulo COUNT.
  - Next edge: grant = 1<<g, select = g, hold = 0, state = BUSY.
  - If req == 0, stay in IDLE; select holds its value.
- **BUSY**
  - On each xfer, hold increments.
  - Release at the edge when either condition is true:
    - req[select] == 0, or
    - xfer && MAX_HOLD != 0 && hold == MAX_HOLD-1.
  - On release: grant = 0, ptr = (select+1) mod COUNT (wraps COUNT-1 → 0), state = IDLE.
- Every release costs exactly one IDLE arbitration cycle, even when other requests are pending.
- Requests from non-granted requesters never affect grant, valid or out while in BUSY.
- req is level-sensitive. A requester that keeps req high is re-granted only after every other active requester has been served.
- ready is ignored while valid == 0. out is meaningful only when valid == 1.
- Reset (any state, including mid-transfer) sets:
  - state = IDLE, grant = 0, select = 0, ptr = 0, hold = 0.
  - No xfer is signalled in the reset cycle; the data in flight is dropped.
- hold is wide enough to represent MAX_HOLD-1. It never wraps, because release occurs at MAX_HOLD-1.

## Timing
- Arbitration latency: req rises in cycle t while in IDLE → grant and valid high in cycle t+1.
- Throughput: one word per cycle while the grantee holds req and downstream holds ready.
- Turnaround: the last transfer of a grant happens in cycle t → IDLE in t+1 → next grant in t+2.
- valid, out and xfer are combinational from registered select/grant and the live req/in/ready. No data register is added.
- The grantee drops req in cycle t → grant is cleared at the end of t; valid is already low in t.
- Simultaneous events:
  - Release and new requests in the same cycle: the new requests are arbitrated in the following IDLE cycle, using the updated ptr.
  - Reset asserted together with req/ready: reset wins.

## Test plan
- Reset, then all req = 0 for 5 cycles → grant = 0, select = 0, valid = 0, xfer = 0 throughout.
- COUNT=4, MAX_HOLD=2, req = 4'b1111, ready = 1 constant, in[i] = 8'hA0+i → grants cycle 0,1,2,3,0. Each grant gives 2 xfers with out = A0, A0, –, A1, A1, –, A2, …, with one idle cycle between grants.
- Grant to requester 2, ready held 0 for 3 cycles, then 1 → valid = 1 and xfer = 0 for 3 cycles, then a transfer. Grant is held; hold counts only the xfers.
- MAX_HOLD=0, only req[1] high for 20 cycles with ready = 1 → grant stays 4'b0010 and 20 consecutive xfers occur. Drop req[1] → grant = 0 on the next edge.
- ptr wrap: grant requester 3, release, req = 4'b1001 → next grant is requester 0, then 3 again after 0 releases.
- Assert reset mid-BUSY (grantee 2, hold = 1) → next cycle grant = 0, select = 0, ptr = 0. With req = 4'b1111, the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/oit_rr_arbiter.sv
// -----------------------------------------------------------------------------
// oit_rr_arbiter
//
// Round-robin arbiter that shares one mux-style datapath between COUNT
// requesters. One requester at a time owns the datapath. The owner's data
// word is forwarded to a single downstream consumer. A hold limit bounds how
// many words one grant may move, so no requester can starve the others.
//
// Parameters
//   COUNT     number of requesters (2..16)
//   WIDTH     bits per data word
//   MAX_HOLD  max transfers per grant; 0 = unlimited
//   SEL_W     derived select width, ceil(log2 COUNT), minimum 1
//
// Ports
//   clock     single clock, everything updates on posedge
//   reset     synchronous, active-high; returns to IDLE with ptr/select at 0
//   req       req[i] high = requester i has a word available (level)
//   in        word of requester i is in[i*WIDTH +: WIDTH]
//   ready     downstream accepts out this cycle
//   grant     registered one-hot grant, all zero while idle
//   select    registered index of the current (or last) grantee
//   valid     grant active and the grantee still requesting
//   out       word of the selected requester (meaningful only with valid)
//   xfer      valid & ready: a word moves this cycle
//   dbg_busy  high while the arbiter is in BUSY
//   dbg_ptr   next priority index used by the IDLE scan
//
// Handshake: a word moves in exactly the cycles where valid and ready are
// both high (xfer). valid never depends on ready, and ready is ignored while
// valid is low. valid may drop without a transfer when the grantee drops
// req; that word is not considered delivered.
// -----------------------------------------------------------------------------
module oit_rr_arbiter #(
  parameter int COUNT    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  localparam int SEL_W   = (COUNT > 2) ? $clog2(COUNT) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [COUNT-1:0]       req,
  input  logic [COUNT*WIDTH-1:0] in,
  input  logic                   ready,
  output logic [COUNT-1:0]       grant,
  output logic [SEL_W-1:0]       select,
  output logic                   valid,
  output logic [WIDTH-1:0]       out,
  output logic                   xfer,
  output logic                   dbg_busy,
  output logic [SEL_W-1:0]       dbg_ptr
);

  // The hold counter only needs to reach MAX_HOLD-1, because the grant is
  // released on the transfer that would take it to MAX_HOLD.
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(COUNT - 1);
  localparam logic [SEL_W:0]   COUNT_EXT = (SEL_W + 1)'(COUNT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold;

  // ---------------------------------------------------------------------------
  // Unpack the flat data bus so the output mux is a plain array read.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] words [COUNT];

  for (genvar i = 0; i < COUNT; i++) begin : g_unpack
    assign words[i] = in[i*WIDTH +: WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Rotating priority scan: first requester found starting at ptr, walking
  // upward with wrap at COUNT. cand is one bit wider than an index so the
  // sum ptr+k can exceed COUNT-1 before being folded back.
  // ---------------------------------------------------------------------------
  logic             arb_found;
  logic [SEL_W-1:0] arb_idx;
  logic [SEL_W:0]   cand;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < COUNT; k++) begin
      cand = {1'b0, ptr} + (SEL_W + 1)'(k);
      if (cand >= COUNT_EXT) begin
        cand = cand - COUNT_EXT;
      end
      if (!arb_found && req[cand[SEL_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[SEL_W-1:0];
      end
    end
  end

  logic [COUNT-1:0] arb_onehot;

  always_comb begin
    arb_onehot          = '0;
    arb_onehot[arb_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Datapath and handshake. These are combinational from the registered
  // grant/select and the live req/in/ready; no data register is added.
  // reset forces valid low so nothing is signalled as delivered in a cycle
  // whose state is being discarded.
  // ---------------------------------------------------------------------------
  logic busy;

  assign busy  = (state == S_BUSY);
  assign valid = busy & req[select] & ~reset;
  assign out   = words[select];
  assign xfer  = valid & ready;

  // ---------------------------------------------------------------------------
  // Release conditions while BUSY: the grantee stops requesting, or the
  // transfer happening now is the last one the hold limit allows.
  // ---------------------------------------------------------------------------
  logic             at_limit;
  logic             release_now;
  logic [SEL_W-1:0] next_ptr;

  assign at_limit    = (MAX_HOLD != 0) && (hold == HOLD_LAST);
  assign release_now = ~req[select] | (xfer & at_limit);
  // Priority moves just past the releasing grantee so it is served last.
  assign next_ptr    = (select == LAST_IDX) ? '0 : select + 1'b1;

  // ---------------------------------------------------------------------------
  // Control FSM with registered grant/select. A release always goes through
  // one IDLE cycle, where the scan uses the freshly updated ptr.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      grant  <= '0;
      select <= '0;
      ptr    <= '0;
      hold   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_found) begin
            state  <= S_BUSY;
            grant  <= arb_onehot;
            select <= arb_idx;
            hold   <= '0;
          end
        end
        S_BUSY: begin
          if (release_now) begin
            state <= S_IDLE;
            grant <= '0;
            ptr   <= next_ptr;
            hold  <= '0;
          end else if (xfer && (MAX_HOLD != 0)) begin
            // With no hold limit the counter is never consulted, so it is
            // left at zero instead of being allowed to wrap.
            hold <= hold + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign dbg_busy = busy;
  assign dbg_ptr  = ptr;

  // ---------------------------------------------------------------------------
  // Structural invariants of the registered grant.
  // ---------------------------------------------------------------------------
  a_grant_onehot0: assert property (
    @(posedge clock) disable iff (reset) $onehot0(grant)
  );

  a_grant_matches_select: assert property (
    @(posedge clock) disable iff (reset)
      busy |-> (grant == (COUNT'(1) << select))
  );

  a_idle_no_grant: assert property (
    @(posedge clock) disable iff (reset) !busy |-> (grant == '0)
  );

  a_select_in_range: assert property (
    @(posedge clock) disable iff (reset) select <= LAST_IDX
  );

endmodule

// File: tb/tb_oit_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_oit_rr_arbiter
//
// Two arbiters share one set of inputs: instance 0 has MAX_HOLD=2, instance 1
// has MAX_HOLD=0 (unlimited). Directed scenarios check exact cycle behaviour
// against hand-derived tables; a randomized run checks both instances every
// cycle against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_oit_rr_arbiter;

  localparam int COUNT = 4;
  localparam int WIDTH = 8;
  localparam int SEL_W = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  logic [COUNT-1:0]       req    = '0;
  logic [COUNT*WIDTH-1:0] in_bus = '0;
  logic                   ready  = 1'b0;

  logic [COUNT-1:0] grant_o  [2];
  logic [SEL_W-1:0] select_o [2];
  logic             valid_o  [2];
  logic [WIDTH-1:0] out_o    [2];
  logic             xfer_o   [2];
  logic             busy_o   [2];
  logic [SEL_W-1:0] ptr_o    [2];

  oit_rr_arbiter #(.COUNT(COUNT), .WIDTH(WIDTH), .MAX_HOLD(2)) dut_a (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .in       (in_bus),
    .ready    (ready),
    .grant    (grant_o[0]),
    .select   (select_o[0]),
    .valid    (valid_o[0]),
    .out      (out_o[0]),
    .xfer     (xfer_o[0]),
    .dbg_busy (busy_o[0]),
    .dbg_ptr  (ptr_o[0])
  );

  oit_rr_arbiter #(.COUNT(COUNT), .WIDTH(WIDTH), .MAX_HOLD(0)) dut_b (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .in       (in_bus),
    .ready    (ready),
    .grant    (grant_o[1]),
    .select   (select_o[1]),
    .valid    (valid_o[1]),
    .out      (out_o[1]),
    .xfer     (xfer_o[1]),
    .dbg_busy (busy_o[1]),
    .dbg_ptr  (ptr_o[1])
  );

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: who owns the bus, how many words the owner has moved in
  // this grant, and where the next round-robin search starts.
  // ---------------------------------------------------------------------------
  int m_owned [2] = '{0, 0};
  int m_owner [2] = '{0, 0};
  int m_start [2] = '{0, 0};
  int m_moved [2] = '{0, 0};
  int m_limit [2] = '{2, 0};

  always @(posedge clock) begin
    for (int j = 0; j < 2; j++) begin
      if (reset) begin
        m_owned[j] = 0;
        m_owner[j] = 0;
        m_start[j] = 0;
        m_moved[j] = 0;
      end else if (m_owned[j] == 0) begin
        for (int k = 0; k < COUNT; k++) begin
          if (m_owned[j] == 0 && req[(m_start[j] + k) % COUNT]) begin
            m_owned[j] = 1;
            m_owner[j] = (m_start[j] + k) % COUNT;
            m_moved[j] = 0;
          end
        end
      end else begin
        if (req[m_owner[j]] && ready) m_moved[j] = m_moved[j] + 1;
        if (!req[m_owner[j]] || (m_limit[j] != 0 && m_moved[j] == m_limit[j])) begin
          m_owned[j] = 0;
          m_start[j] = (m_owner[j] + 1) % COUNT;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: apply inputs just after a rising edge, return at the falling edge
  // where outputs are sampled.
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic [COUNT-1:0] r, input logic rdy, input logic rst);
    @(posedge clock);
    #1;
    req   = r;
    ready = rdy;
    reset = rst;
    @(negedge clock);
  endtask

  task automatic do_reset();
    cyc('0, 1'b0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [15:0] got;
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      cyc('0, 1'b0, 1'b0);
      for (int j = 0; j < 2; j++) begin
        got = {grant_o[j], select_o[j], valid_o[j], xfer_o[j], busy_o[j],
               ptr_o[j], 4'h0};
        total++;
        if (got !== 16'h0000) begin
          bad++;
          $display("FAIL reset_idle inst=%0d c=%0d got=%h exp=%h", j, c, got, 16'h0000);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [13:0] got, exp;
    int g;
    in_bus = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    do_reset();
    for (int c = 0; c < 15; c++) begin
      cyc(4'b1111, 1'b1, 1'b0);
      if (c % 3 == 0) begin
        exp = '0;
      end else begin
        g   = (c / 3) % COUNT;
        exp = {4'(1 << g), 1'b1, 1'b1, 8'(8'hA0 + g)};
      end
      got = {grant_o[0], valid_o[0], xfer_o[0], valid_o[0] ? out_o[0] : 8'h00};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL round_robin c=%0d got=%h exp=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_ready_stall();
    logic [3:0] eg [7] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
    logic       ev [7] = '{0, 1, 1, 1, 1, 1, 0};
    logic       ex [7] = '{0, 0, 0, 0, 1, 1, 0};
    logic       rd [7] = '{0, 0, 0, 0, 1, 1, 1};
    logic [15:0] got, exp;
    in_bus = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cyc(4'b0100, rd[c], 1'b0);
      exp = {eg[c], ev[c], ex[c], ev[c] ? 8'hA2 : 8'h00, (c == 0) ? 2'd0 : 2'd2};
      got = {grant_o[0], valid_o[0], xfer_o[0], valid_o[0] ? out_o[0] : 8'h00,
             select_o[0]};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL ready_stall c=%0d got=%h exp=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_unlimited();
    int n_xfer = 0;
    logic [5:0] got;
    do_reset();
    cyc(4'b0010, 1'b1, 1'b0);
    total++;
    if (grant_o[1] !== 4'b0000) begin
      bad++;
      $display("FAIL unlim_arb got=%b exp=%b", grant_o[1], 4'b0000);
    end
    for (int c = 0; c < 20; c++) begin
      cyc(4'b0010, 1'b1, 1'b0);
      n_xfer += int'(xfer_o[1]);
      got = {grant_o[1], valid_o[1], xfer_o[1]};
      total++;
      if (got !== 6'b0010_1_1) begin
        bad++;
        $display("FAIL unlim_hold c=%0d got=%b exp=%b", c, got, 6'b0010_1_1);
      end
    end
    total++;
    if (n_xfer != 20) begin
      bad++;
      $display("FAIL unlim_count got=%0d exp=%0d", n_xfer, 20);
    end
    cyc(4'b0000, 1'b1, 1'b0);
    got = {grant_o[1], valid_o[1], xfer_o[1]};
    total++;
    if (got !== 6'b0010_0_0) begin
      bad++;
      $display("FAIL unlim_drop got=%b exp=%b", got, 6'b0010_0_0);
    end
    cyc(4'b0000, 1'b1, 1'b0);
    total++;
    if (grant_o[1] !== 4'b0000) begin
      bad++;
      $display("FAIL unlim_release got=%b exp=%b", grant_o[1], 4'b0000);
    end
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] rq [8] = '{4'h8, 4'h8, 4'h8, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};
    logic [3:0] eg [8] = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0, 4'h8};
    logic [1:0] es [8] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3};
    logic [5:0] got, exp;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc(rq[c], 1'b1, 1'b0);
      exp = {eg[c], es[c]};
      got = {grant_o[0], select_o[0]};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL ptr_wrap c=%0d got=%h exp=%h", c, got, exp);
      end
      if (c == 3) begin
        total++;
        if (ptr_o[0] !== 2'd0) begin
          bad++;
          $display("FAIL ptr_wrap_ptr got=%0d exp=%0d", ptr_o[0], 0);
        end
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [7:0] got;
    do_reset();
    cyc(4'b0100, 1'b1, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    got = {grant_o[0], 2'b00, valid_o[0], xfer_o[0]};
    total++;
    if (got !== 8'b0100_00_1_1) begin
      bad++;
      $display("FAIL midbusy_pre got=%b exp=%b", got, 8'b0100_00_1_1);
    end
    cyc(4'b1111, 1'b1, 1'b1);
    got = {4'h0, 2'b00, valid_o[0], xfer_o[0]};
    total++;
    if (got !== 8'h00) begin
      bad++;
      $display("FAIL midbusy_rst_xfer got=%b exp=%b", got, 8'h00);
    end
    cyc(4'b1111, 1'b1, 1'b0);
    got = {grant_o[0], select_o[0], ptr_o[0]};
    total++;
    if (got !== 8'h00) begin
      bad++;
      $display("FAIL midbusy_after got=%h exp=%h", got, 8'h00);
    end
    cyc(4'b1111, 1'b1, 1'b0);
    got = {grant_o[0], select_o[0], 2'b00};
    total++;
    if (got !== 8'b0001_00_00) begin
      bad++;
      $display("FAIL midbusy_first_grant got=%b exp=%b", got, 8'b0001_00_00);
    end
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    logic [COUNT-1:0] r;
    logic [COUNT-1:0] e_grant;
    logic e_valid;
    do_reset();
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < COUNT; i++) begin
        if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
      end
      in_bus = {$urandom};
      cyc(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
      for (int j = 0; j < 2; j++) begin
        e_grant = (m_owned[j] != 0) ? 4'(1 << m_owner[j]) : 4'b0;
        e_valid = (m_owned[j] != 0) && req[m_owner[j]] && !reset;
        exp = {e_grant, 2'(m_owner[j]), e_valid, e_valid && ready,
               e_valid ? in_bus[m_owner[j]*WIDTH +: WIDTH] : 8'h00};
        got = {grant_o[j], select_o[j], valid_o[j], xfer_o[j],
               valid_o[j] ? out_o[j] : 8'h00};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL random inst=%0d c=%0d got=%h exp=%h", j, c, got, exp);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_round_robin();
    test_ready_stall();
    test_unlimited();
    test_ptr_wrap();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
